// File: rtl/tacky_pkg.sv
// Shared definitions for the Tacky memory responder: word width, FSM encodings
// and the legal wait-state range.
package tacky_pkg;

  localparam int WORD    = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic [WORD-1:0] word_t;

  // Counter preload for a given latency, clamped to the supported range.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    int l;
    l = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/tacky_mem_array.sv
// DEPTH x WORD storage: synchronous write, combinational read on a shared address.
module tacky_mem_array
  import tacky_pkg::*;
#(
  parameter int DEPTH = 65536
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  word_t                    wdata,
  output word_t                    rdata
);

  word_t mem [DEPTH];

  // NOTE: storage deliberately has no reset; contents must survive a reset pulse
  // and a reset on every word would also stop this mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/tacky_mem_responder.sv
// Valid/ready memory responder for the Tacky processor with LATENCY wait states.
// Optional feature: define MEM_WRITE_ACK_EN to make stores return a response too.
module tacky_mem_responder
  import tacky_pkg::*;
#(
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = lat_load(LATENCY);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  word_t            wdata_q;
  word_t            rsp_q;
  word_t            arr_rdata;
  logic             done;
  logic             accept;

  assign done   = (state == ST_WAIT) && (cnt == '0);
  assign accept = req_valid && req_ready;

  tacky_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (done && we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_WAIT;
            cnt     <= CNT_LOAD;
            we_q    <= req_we;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!we_q) begin
            rsp_q <= arr_rdata;
            state <= ST_RESP;
          end else begin
`ifdef MEM_WRITE_ACK_EN
            rsp_q <= wdata_q;
            state <= ST_RESP;
`else
            state <= ST_IDLE;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated with reset so the processor never sees ready while reset is held.
  assign req_ready = (state == ST_IDLE) && reset;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rsp_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_tacky_mem_responder.sv
// Directed bench for tacky_mem_responder: four instances covering full depth,
// DEPTH=256 address wrap, LATENCY=1 and LATENCY=15.
`timescale 1ns/1ps
module tb_tacky_mem_responder;

`ifdef MEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we    [4];
  logic [15:0] req_addr  [4];
  logic [15:0] req_wdata [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [15:0] rsp_rdata [4];
  logic        busy      [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 65536 : 256;
    localparam int L = (g == 2) ? 1 : ((g == 3) ? 15 : 2);
    tacky_mem_responder #(.DEPTH(D), .LATENCY(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(input int idx);
    return (idx == 2) ? 1 : ((idx == 3) ? 15 : 2);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; checks latency and result.
  task automatic transact(input int idx, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp,
                          input string name);
    int lat;
    int guard;
    bit early;
    lat   = lat_of(idx);
    guard = 0;
    @(negedge clk);
    while (!req_ready[idx] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready"}, 16'(req_ready[idx]), 16'd1);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    early = 1'b0;
    for (int k = 0; k < lat - 1; k++) begin
      if (rsp_valid[idx]) early = 1'b1;
      @(posedge clk); #1;
    end
    if (rsp_valid[idx]) early = 1'b1;
    check({name, "_early"}, 16'(early), 16'd0);
    check({name, "_busy"}, 16'(busy[idx]), 16'd1);
    @(posedge clk); #1;
    if (!we || ACK) begin
      check({name, "_valid"}, 16'(rsp_valid[idx]), 16'd1);
      check({name, "_data"}, rsp_rdata[idx], exp);
      @(posedge clk); #1;
      check({name, "_idle"}, 16'(rsp_valid[idx]), 16'd0);
      check({name, "_rdy_back"}, 16'(req_ready[idx]), 16'd1);
    end else begin
      check({name, "_no_rsp"}, 16'(rsp_valid[idx]), 16'd0);
      check({name, "_rdy_back"}, 16'(req_ready[idx]), 16'd1);
    end
  endtask

  typedef struct {
    int          inst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    forever begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
    end
  end

  initial begin
    bit stable;

    vecs.push_back('{0, 1'b1, 16'h0010, 16'h1234, 16'h1234, "wr_0010"});
    vecs.push_back('{0, 1'b0, 16'h0010, 16'h0000, 16'h1234, "rd_0010"});
    vecs.push_back('{0, 1'b1, 16'h0020, 16'hBEEF, 16'hBEEF, "wr_0020"});
    vecs.push_back('{0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, "rd_0020"});
    vecs.push_back('{0, 1'b1, 16'hFFFF, 16'h0F0F, 16'h0F0F, "wr_ffff"});
    vecs.push_back('{0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, "rd_ffff"});
    vecs.push_back('{0, 1'b1, 16'h0030, 16'hAAAA, 16'hAAAA, "wr_0030"});
    vecs.push_back('{1, 1'b1, 16'h0005, 16'h00A5, 16'h00A5, "d256_wr_05"});
    vecs.push_back('{1, 1'b0, 16'h0105, 16'h0000, 16'h00A5, "d256_rd_105"});
    vecs.push_back('{1, 1'b1, 16'h02FF, 16'h5A5A, 16'h5A5A, "d256_wr_2ff"});
    vecs.push_back('{1, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A, "d256_rd_ff"});
    vecs.push_back('{2, 1'b1, 16'h0007, 16'h1111, 16'h1111, "lat1_wr"});
    vecs.push_back('{2, 1'b0, 16'h0007, 16'h0000, 16'h1111, "lat1_rd_a"});
    vecs.push_back('{2, 1'b0, 16'h0007, 16'h0000, 16'h1111, "lat1_rd_b"});
    vecs.push_back('{3, 1'b1, 16'h0009, 16'h2222, 16'h2222, "lat15_wr"});
    vecs.push_back('{3, 1'b0, 16'h0009, 16'h0000, 16'h2222, "lat15_rd_a"});
    vecs.push_back('{3, 1'b0, 16'h0009, 16'h0000, 16'h2222, "lat15_rd_b"});

    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b1;
    end

    // Reset values while reset is held, then ready right after release.
    reset = 1'b0;
    #3;
    check("rst_req_ready", 16'(req_ready[0]), 16'd0);
    check("rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 16'h0000);
    check("rst_busy", 16'(busy[0]), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_req_ready", 16'(req_ready[0]), 16'd1);
    check("rel_busy", 16'(busy[0]), 16'd0);

    foreach (vecs[i])
      transact(vecs[i].inst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);

    // Response backpressure: hold rsp_ready low for 5 cycles in RESP.
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 16'h0010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_valid", 16'(rsp_valid[0]), 16'd1);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid[0] || rsp_rdata[0] !== 16'h1234 || req_ready[0] || !busy[0])
        stable = 1'b0;
    end
    check("bp_stable", 16'(stable), 16'd1);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 16'(rsp_valid[0]), 16'd0);
    check("bp_release_ready", 16'(req_ready[0]), 16'd1);

    // Reset during WAIT of a write: write dropped, outputs reset asynchronously.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0030;
    req_wdata[0] = 16'h5555;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_we[0]    = 1'b0;
    check("mid_busy", 16'(busy[0]), 16'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", 16'(req_ready[0]), 16'd0);
    check("mid_rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("mid_rst_rsp_rdata", rsp_rdata[0], 16'h0000);
    check("mid_rst_busy", 16'(busy[0]), 16'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    transact(0, 1'b0, 16'h0030, 16'h0000, 16'hAAAA, "rd_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tacky_mem_responder.md
# tacky_mem_responder

Memory-side responder for the Tacky multi-cycle processor: services single-word instruction fetches, loads and stores issued by the processor over a valid/ready request channel and a valid/ready response channel. The responder owns a word-addressed 16-bit memory array and inserts a programmable number of wait states. It replaces the processor's direct, zero-latency access to its internal memory array, so that the processor becomes the initiator of a real memory protocol.

## Interface
- DEPTH, 65536, number of 16-bit words; power of two, 2..65536
- LATENCY, 2, cycles from request acceptance to response/completion; legal range 1..15
- clk  input  1  clock; all state changes on posedge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  processor presents a request
- req_ready  output  1  responder accepts a request this cycle
- req_we  input  1  1 = store, 0 = load/fetch
- req_addr  input  16  word address
- req_wdata  input  16  store data
- rsp_valid  output  1  response data valid
- rsp_ready  input  1  processor consumes the response
- rsp_rdata  output  16  read data (or echoed store data, see Configuration)
- busy  output  1  a request is in flight (state != IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata, load counter with LATENCY-1, go to WAIT; if LATENCY=1, go directly to completion (below).
- WAIT: req_ready=0. Counter decrements each cycle; completion occurs when the counter is 0.
- Completion, read: capture array[addr] into rsp_rdata and go to RESP.
- Completion, write: commit wdata to array[addr], then proceed as described in Configuration.
- RESP: rsp_valid=1. rsp_rdata is held stable until rsp_ready=1, then go to IDLE. No new request is accepted in the same cycle.
- Address wrap: only the low log2(DEPTH) bits of req_addr index the array. Higher bits are ignored, with no error.
- rsp_ready while not in RESP is ignored. req_valid while req_ready=0 is ignored; the processor must hold the request.
- Array contents are not affected by reset.

## Timing
- Reset values: req_ready=0 during reset, 1 in the first cycle after release; rsp_valid=0; rsp_rdata=0; busy=0; state=IDLE; counter=0.
- Reset mid-operation: abort to IDLE. A write not yet committed is dropped. A pending response is discarded.
- Acceptance is at edge T. rsp_valid rises at edge T+LATENCY. A read after a write to the same address returns the new data.
- Minimum cycle per transaction is LATENCY+2 edges with rsp_ready held high (accept, wait, RESP, return to IDLE).
- The write commit happens at edge T+LATENCY.

## Configuration
- MEM_WRITE_ACK_EN defined: writes also enter RESP. rsp_valid pulses with rsp_rdata = the written data, and the processor must handshake with rsp_ready.
- MEM_WRITE_ACK_EN undefined: writes go from completion straight to IDLE with no rsp_valid. req_ready reasserts at edge T+LATENCY.

## Structure
- Shared package tacky_pkg holds:
  - the WORD width (16)
  - state encodings IDLE/WAIT/RESP
  - the LATENCY bounds
- Sub-module tacky_mem_array: DEPTH x 16 storage with a synchronous write port and a combinational read port, instantiated once.
- The FSM, the counter and the response register live in tacky_mem_responder.

## Test plan
- Reset, then a read of addr 0x0010 with preload 0x1234, LATENCY=2, rsp_ready=1 -> rsp_valid at T+2, rsp_rdata=0x1234, then IDLE with req_ready=1 one cycle later.
- Write 0xBEEF to 0x0020, then read 0x0020 -> read returns 0xBEEF. With MEM_WRITE_ACK_EN, the write response carries 0xBEEF; without it, no rsp_valid occurs for the write.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; the state leaves RESP on the edge where rsp_ready=1.
- DEPTH=256, read addr 0x0105 -> returns the contents of word 0x05.
- Assert reset during WAIT of a write of 0x5555 to 0x0030, with 0x0030 preloaded to 0xAAAA -> after release a read of 0x0030 returns 0xAAAA, and all outputs took their reset values asynchronously.
- LATENCY=1 and LATENCY=15 back-to-back reads -> rsp_valid at T+1 and T+15 respectively; the counter never wraps.
